// File: rtl/receiver.sv
// UART-style serial receiver: 2-flop synchronized Rx, 8N1 framing, mid-bit sampling.
// Define RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module receiver #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Rx,
  input  logic       RxEn,
  output logic [7:0] RxData,
  output logic       RxDone,
  output logic       RxErr,
  output logic       ParErr
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t          r_state;
  logic            r_rx_m;
  logic            r_rx_s;
  logic            r_armed;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            w_cnt_half;
  logic            w_cnt_last;
`ifdef RX_PARITY_EN
  logic            r_par_bad;
  logic            r_par_err;
`endif

  assign w_cnt_half = (r_cnt == HALF_LAST);
  assign w_cnt_last = (r_cnt == BIT_LAST);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state   <= S_IDLE;
      r_rx_m    <= 1'b1;
      r_rx_s    <= 1'b1;
      r_armed   <= 1'b0;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      RxData    <= 8'h00;
      RxDone    <= 1'b0;
      RxErr     <= 1'b0;
`ifdef RX_PARITY_EN
      r_par_bad <= 1'b0;
      r_par_err <= 1'b0;
`endif
    end else begin
      r_rx_m    <= Rx;
      r_rx_s    <= r_rx_m;
      RxDone    <= 1'b0;
      RxErr     <= 1'b0;
`ifdef RX_PARITY_EN
      r_par_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          // armed blocks a line stuck low from starting frame after frame
          if (r_rx_s) r_armed <= 1'b1;
          if (!r_rx_s && RxEn && r_armed) begin
            r_state <= S_START;
            r_armed <= 1'b0;
            r_cnt   <= '0;
            r_bit   <= '0;
          end
        end
        S_START: begin
          if (w_cnt_half) begin
            r_cnt   <= '0;
            r_state <= r_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_cnt_last) begin
            r_cnt          <= '0;
            r_shift[r_bit] <= r_rx_s;
            r_bit          <= r_bit + 3'd1;
`ifdef RX_PARITY_EN
            if (r_bit == 3'd7) r_state <= S_PARITY;
`else
            if (r_bit == 3'd7) r_state <= S_STOP;
`endif
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`ifdef RX_PARITY_EN
        S_PARITY: begin
          if (w_cnt_last) begin
            r_cnt     <= '0;
            r_par_bad <= ^{r_shift, r_rx_s};
            r_state   <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`endif
        S_STOP: begin
          // leave at mid-stop so a start bit right after the stop bit is caught
          if (w_cnt_last) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            if (!r_rx_s) begin
              RxErr <= 1'b1;
`ifdef RX_PARITY_EN
            end else if (r_par_bad) begin
              r_par_err <= 1'b1;
`endif
            end else begin
              RxData <= r_shift;
              RxDone <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef RX_PARITY_EN
  assign ParErr = r_par_err;
`else
  assign ParErr = 1'b0;
`endif

endmodule

// File: tb/tb_receiver.sv
// Randomized + directed bench for receiver; frame outcomes predicted from the framing rules.
module tb_receiver;

  localparam int CPB = 16;
`ifdef RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int LAT = 2 + (CPB*19)/2 + 1 + (PAR_EN ? CPB : 0);

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Rx = 1'b1;
  logic       RxEn = 1'b0;
  logic [7:0] RxData;
  logic       RxDone, RxErr, ParErr;

  receiver #(.CLKS_PER_BIT(CPB)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Rx(Rx), .RxEn(RxEn),
    .RxData(RxData), .RxDone(RxDone), .RxErr(RxErr), .ParErr(ParErr)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0, n_errors = 0;
  int cyc = 0;
  int cnt_done = 0, cnt_rxerr = 0, cnt_parerr = 0, cnt_multi = 0, cnt_wide = 0;
  int last_done_cyc = 0;
  logic prev_done = 0, prev_err = 0, prev_par = 0;
  logic [7:0] done_q[$];
  logic [7:0] exp_data = 8'h00;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (RxDone) begin cnt_done++; done_q.push_back(RxData); last_done_cyc = cyc; end
    if (RxErr)  cnt_rxerr++;
    if (ParErr) cnt_parerr++;
    if (int'(RxDone) + int'(RxErr) + int'(ParErr) > 1) cnt_multi++;
    if ((RxDone && prev_done) || (RxErr && prev_err) || (ParErr && prev_par)) cnt_wide++;
    prev_done = RxDone; prev_err = RxErr; prev_par = ParErr;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // all line driving happens #1 after a rising edge
  task automatic bit_out(input logic b);
    Rx = b;
    repeat (CPB) @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    Rx = 1'b1;
    if (n > 0) begin
      repeat (n) @(posedge Clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic stop_v, input logic pflip, output int st);
    st = cyc;
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    if (PAR_EN) bit_out((^d) ^ pflip);
    bit_out(stop_v);
  endtask

  task automatic frame(input logic [7:0] d, input logic stop_v, input logic pflip,
                       input int gap_bits, input logic listen, input string tag);
    int d0, e0, p0, st, lat;
    logic x_done, x_err, x_par;
    d0 = cnt_done; e0 = cnt_rxerr; p0 = cnt_parerr;
    x_err  = listen && !stop_v;
    x_par  = listen && stop_v && PAR_EN && pflip;
    x_done = listen && stop_v && !x_par;
    send(d, stop_v, pflip, st);
    idle(gap_bits * CPB);
    chk({tag, ".done"}, cnt_done - d0, 32'(x_done));
    chk({tag, ".err"}, cnt_rxerr - e0, 32'(x_err));
    chk({tag, ".par"}, cnt_parerr - p0, 32'(x_par));
    if (x_done) begin
      exp_data = d;
      if (done_q.size() == 0) chk({tag, ".q"}, 32'hFFFF, 32'(d));
      else                    chk({tag, ".q"}, 32'(done_q.pop_front()), 32'(d));
      lat = last_done_cyc - st;
      chk({tag, ".lat"}, (lat >= LAT-1 && lat <= LAT+1) ? LAT : lat, LAT);
    end
    chk({tag, ".data"}, 32'(RxData), 32'(exp_data));
  endtask

  initial begin
    int d0, e0, p0, st;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst.data", 32'(RxData), 32'h00);
    chk("rst.pulses", {29'd0, RxDone, RxErr, ParErr}, 32'h0);
    Rst_n = 1'b1;
    RxEn  = 1'b1;
    idle(2 * CPB);

    frame(8'h15, 1'b1, 1'b0, 2, 1'b1, "basic");
    frame(8'h08, 1'b1, 1'b0, 0, 1'b1, "b2b0");
    frame(8'h06, 1'b1, 1'b0, 1, 1'b1, "b2b1");

    // short glitch on the line must be rejected at mid-start
    d0 = cnt_done; e0 = cnt_rxerr; p0 = cnt_parerr;
    Rx = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    idle(3 * CPB);
    chk("glitch.pulses", (cnt_done - d0) + (cnt_rxerr - e0) + (cnt_parerr - p0), 0);
    frame(8'h09, 1'b1, 1'b0, 1, 1'b1, "post_glitch");

    // framing error followed by a line stuck low
    d0 = cnt_done; e0 = cnt_rxerr;
    send(8'hA5, 1'b0, 1'b0, st);
    repeat (100) @(posedge Clk);
    #1;
    chk("stuck.err", cnt_rxerr - e0, 1);
    chk("stuck.done", cnt_done - d0, 0);
    chk("stuck.data", 32'(RxData), 32'(exp_data));
    idle(2 * CPB);
    chk("stuck.norestart", (cnt_rxerr - e0) + (cnt_done - d0), 1);
    frame(8'h3C, 1'b1, 1'b0, 1, 1'b1, "post_stuck");

    // reset in the middle of data bit 3
    d0 = cnt_done; e0 = cnt_rxerr; p0 = cnt_parerr;
    bit_out(1'b0);
    for (int i = 0; i < 3; i++) bit_out(1'b1);
    Rx = 1'b0;
    repeat (CPB/2) @(posedge Clk);
    #1;
    Rst_n = 1'b0;
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    exp_data = 8'h00;
    chk("midrst.data", 32'(RxData), 32'h00);
    chk("midrst.out", {29'd0, RxDone, RxErr, ParErr}, 32'h0);
    idle(12 * CPB);
    chk("midrst.pulses", (cnt_done - d0) + (cnt_rxerr - e0) + (cnt_parerr - p0), 0);
    frame(8'h0A, 1'b1, 1'b0, 1, 1'b1, "post_rst");

    RxEn = 1'b0;
    frame(8'h33, 1'b1, 1'b0, 1, 1'b0, "en_off");
    RxEn = 1'b1;
    idle(CPB);
    fork
      frame(8'h5C, 1'b1, 1'b0, 1, 1'b1, "en_drop");
      begin
        repeat (3*CPB) @(posedge Clk);
        #2 RxEn = 1'b0;
        repeat (CPB) @(posedge Clk);
        #2 RxEn = 1'b1;
      end
    join

    if (PAR_EN) begin
      frame(8'h07, 1'b1, 1'b1, 1, 1'b1, "par_bad");
      frame(8'h07, 1'b1, 1'b0, 1, 1'b1, "par_good");
      frame(8'h81, 1'b0, 1'b1, 1, 1'b1, "par_bad_stop");
    end

    for (int k = 0; k < 24; k++) begin
      logic [7:0] d;
      logic sv, pf;
      int gap;
      d   = 8'($urandom);
      sv  = ($urandom_range(0, 7) != 0);
      pf  = ($urandom_range(0, 5) == 0);
      gap = sv ? $urandom_range(0, 2) : $urandom_range(1, 2);
      frame(d, sv, pf, gap, 1'b1, "rnd");
    end

    idle(2 * CPB);
    chk("exclusive", cnt_multi, 0);
    chk("onecycle", cnt_wide, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
